// File: rtl/bmp_stream_if.sv
// bmp_stream_if
// Groups the control, pixel-input and byte-output handshake signals of the
// BMP stream writer.
//   start, gray_mode       : frame request and colour-mode select
//   pix_valid / pix_ready  : pixel handshake carrying red, green, blue, gray
//   out_valid / out_ready  : byte handshake carrying out_data
//   busy, done             : frame status
// Modport slave is the writer; modport master is whoever drives it.
`timescale 1ns/1ps
interface bmp_stream_if;
  logic       start;
  logic       gray_mode;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [7:0] gray;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport slave (
    input  start, gray_mode, pix_valid, red, green, blue, gray, out_ready,
    output pix_ready, out_data, out_valid, busy, done
  );

  modport master (
    output start, gray_mode, pix_valid, red, green, blue, gray, out_ready,
    input  pix_ready, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer
// Turns a pixel stream (RGB or grayscale) into the byte stream of a 24-bit
// uncompressed BMP file: a 54-byte header built from the image size
// parameters, then each row as B,G,R byte triplets followed by zero bytes
// that pad the row to a multiple of 4.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : bmp_stream_if.slave (start/gray_mode, pixel handshake, byte
//           handshake, busy/done)
`timescale 1ns/1ps
module bmp_stream_writer #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 148
) (
  input  logic         clk,
  input  logic         reset,
  bmp_stream_if.slave  bus
);

  localparam int ROW_BYTES = 3 * IMG_WIDTH;
  localparam int STRIDE    = ((ROW_BYTES + 3) / 4) * 4;
  localparam int PAD       = STRIDE - ROW_BYTES;
  localparam int IMG_SIZE  = STRIDE * IMG_HEIGHT;
  localparam int FILE_SIZE = 54 + IMG_SIZE;

  localparam logic [11:0] LAST_COL = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] LAST_ROW = 12'(IMG_HEIGHT - 1);
  // Only meaningful when PAD > 0; the PAD state is unreachable otherwise.
  localparam logic [1:0]  LAST_PAD = 2'(PAD - 1);
  localparam logic [5:0]  LAST_HDR = 6'd53;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PIXEL, S_PAD, S_DONE} state_t;

  // Header byte at position idx; all multi-byte fields are little-endian.
  function automatic logic [7:0] hdr_value(input int idx);
    logic [31:0] word;
    int          off;
    word = 32'd0;
    off  = 0;
    if (idx == 0)                      word = 32'd66;
    else if (idx == 1)                 word = 32'd77;
    else if (idx >= 2  && idx <= 5)  begin word = 32'(FILE_SIZE);  off = idx - 2;  end
    else if (idx >= 10 && idx <= 13) begin word = 32'd54;          off = idx - 10; end
    else if (idx >= 14 && idx <= 17) begin word = 32'd40;          off = idx - 14; end
    else if (idx >= 18 && idx <= 21) begin word = 32'(IMG_WIDTH);  off = idx - 18; end
    else if (idx >= 22 && idx <= 25) begin word = 32'(IMG_HEIGHT); off = idx - 22; end
    else if (idx >= 26 && idx <= 27) begin word = 32'd1;           off = idx - 26; end
    else if (idx >= 28 && idx <= 29) begin word = 32'd24;          off = idx - 28; end
    else if (idx >= 34 && idx <= 37) begin word = 32'(IMG_SIZE);   off = idx - 34; end
    word = word >> (8 * off);
    return word[7:0];
  endfunction

  // Header is fully determined by parameters, so it folds to constants.
  logic [7:0] hdr_rom [54];
  generate
    for (genvar gi = 0; gi < 54; gi++) begin : g_hdr
      assign hdr_rom[gi] = hdr_value(gi);
    end
  endgenerate

  state_t      state_reg,     state_next;
  logic [5:0]  hdr_idx_reg,   hdr_idx_next;
  logic [11:0] col_reg,       col_next;
  logic [11:0] row_reg,       row_next;
  logic [1:0]  pad_cnt_reg,   pad_cnt_next;
  logic [1:0]  byte_sel_reg,  byte_sel_next;   // 0 = B, 1 = G, 2 = R
  logic        hold_full_reg, hold_full_next;
  logic [7:0]  hold_b_reg,    hold_b_next;
  logic [7:0]  hold_g_reg,    hold_g_next;
  logic [7:0]  hold_r_reg,    hold_r_next;
  logic        gray_mode_reg, gray_mode_next;

  logic [7:0]  pix_byte;
  logic        last_col;

  always_comb begin
    state_next     = state_reg;
    hdr_idx_next   = hdr_idx_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    pad_cnt_next   = pad_cnt_reg;
    byte_sel_next  = byte_sel_reg;
    hold_full_next = hold_full_reg;
    hold_b_next    = hold_b_reg;
    hold_g_next    = hold_g_reg;
    hold_r_next    = hold_r_reg;
    gray_mode_next = gray_mode_reg;
    bus.out_valid  = 1'b0;
    bus.out_data   = 8'd0;
    bus.pix_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;

    last_col = (col_reg == LAST_COL);
    case (byte_sel_reg)
      2'd0:    pix_byte = hold_b_reg;
      2'd1:    pix_byte = hold_g_reg;
      default: pix_byte = hold_r_reg;
    endcase

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next     = S_HEADER;
          gray_mode_next = bus.gray_mode;
          hdr_idx_next   = 6'd0;
          col_next       = 12'd0;
          row_next       = 12'd0;
          pad_cnt_next   = 2'd0;
          byte_sel_next  = 2'd0;
          hold_full_next = 1'b0;
        end
      end

      S_HEADER: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = hdr_rom[hdr_idx_reg];
        if (bus.out_ready) begin
          if (hdr_idx_reg == LAST_HDR) begin
            state_next   = S_PIXEL;
            hdr_idx_next = 6'd0;
          end else begin
            hdr_idx_next = hdr_idx_reg + 6'd1;
          end
        end
      end

      S_PIXEL: begin
        bus.busy      = 1'b1;
        bus.out_valid = hold_full_reg;
        bus.out_data  = hold_full_reg ? pix_byte : 8'd0;
        // A new pixel may enter in the same cycle the R byte leaves, except
        // at the end of a row where the next byte is padding or a new row.
        bus.pix_ready = !hold_full_reg ||
                        (byte_sel_reg == 2'd2 && bus.out_ready && !last_col);
        if (hold_full_reg && bus.out_ready) begin
          if (byte_sel_reg != 2'd2) begin
            byte_sel_next = byte_sel_reg + 2'd1;
          end else begin
            byte_sel_next  = 2'd0;
            hold_full_next = 1'b0;
            if (last_col) begin
              col_next = 12'd0;
              if (PAD > 0)                  state_next = S_PAD;
              else if (row_reg == LAST_ROW) state_next = S_DONE;
              else                          row_next   = row_reg + 12'd1;
            end else begin
              col_next = col_reg + 12'd1;
            end
          end
        end
        // Loading wins over the clear above when a pixel arrives on the R byte.
        if (bus.pix_valid && bus.pix_ready) begin
          hold_full_next = 1'b1;
          hold_b_next    = gray_mode_reg ? bus.gray : bus.blue;
          hold_g_next    = gray_mode_reg ? bus.gray : bus.green;
          hold_r_next    = gray_mode_reg ? bus.gray : bus.red;
        end
      end

      S_PAD: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (pad_cnt_reg == LAST_PAD) begin
            pad_cnt_next = 2'd0;
            if (row_reg == LAST_ROW) begin
              state_next = S_DONE;
            end else begin
              row_next   = row_reg + 12'd1;
              state_next = S_PIXEL;
            end
          end else begin
            pad_cnt_next = pad_cnt_reg + 2'd1;
          end
        end
      end

      S_DONE: begin
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      hdr_idx_reg   <= 6'd0;
      col_reg       <= 12'd0;
      row_reg       <= 12'd0;
      pad_cnt_reg   <= 2'd0;
      byte_sel_reg  <= 2'd0;
      hold_full_reg <= 1'b0;
      hold_b_reg    <= 8'd0;
      hold_g_reg    <= 8'd0;
      hold_r_reg    <= 8'd0;
      gray_mode_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hdr_idx_reg   <= hdr_idx_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      pad_cnt_reg   <= pad_cnt_next;
      byte_sel_reg  <= byte_sel_next;
      hold_full_reg <= hold_full_next;
      hold_b_reg    <= hold_b_next;
      hold_g_reg    <= hold_g_next;
      hold_r_reg    <= hold_r_next;
      gray_mode_reg <= gray_mode_next;
    end
  end

endmodule

// File: doc/bmp_stream_writer.md
# bmp_stream_writer

Synthesisable BMP frame formatter. It converts a pixel stream from the image-processing pipeline (RGB or grayscale) into the exact byte stream of a 24-bit uncompressed BMP file: a generated 54-byte header, then pixel bytes with per-row padding. It sits between `img_processing` and any byte sink (UART, SD writer, simulation file dump), replacing hand-written headers with header generation driven by parameters. It adds backpressure, a grayscale mode and row padding for arbitrary widths.

## Interface
- `IMG_WIDTH`, default 160: pixels per row, legal range 1..4095.
- `IMG_HEIGHT`, default 148: rows per frame, legal range 1..4095.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start`  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- `gray_mode`  in  1  sampled on an accepted `start` and held for the whole frame. 1 = use `gray`; 0 = use `red`/`green`/`blue`.
- `pix_valid`  in  1  input pixel is valid.
- `pix_ready`  out  1  writer accepts a pixel this cycle.
- `red`, `green`, `blue`  in  8 each  RGB pixel.
- `gray`  in  8  grayscale pixel.
- `out_data`  out  8  output byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the byte.
- `busy`  out  1  high from an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last byte of the frame transfers.

## Operation
- Derived constants:
  - ROW_BYTES = 3·IMG_WIDTH.
  - STRIDE = ROW_BYTES rounded up to a multiple of 4.
  - PAD = STRIDE − ROW_BYTES (0..3).
  - IMG_SIZE = STRIDE·IMG_HEIGHT.
  - FILE_SIZE = 54 + IMG_SIZE.
  - All size fields are 32-bit little-endian.
- Header byte map; every byte not listed is 0:
  - [0..1] = 66, 77 ("BM").
  - [2..5] = FILE_SIZE.
  - [10..13] = 54.
  - [14..17] = 40.
  - [18..21] = IMG_WIDTH.
  - [22..25] = IMG_HEIGHT (positive, so rows are bottom-up; the producer supplies rows in file order).
  - [26..27] = 1.
  - [28..29] = 24.
  - [34..37] = IMG_SIZE.
- States:
  - IDLE → HEADER on `start` (while not in reset). In HEADER, the header index runs 0..53, one byte per transfer.
  - HEADER → PIXEL after byte 53 transfers.
  - PIXEL: accept a pixel into a holding register, then emit three bytes in order B, G, R. In gray mode all three bytes equal the latched `gray`.
  - After the R byte of column IMG_WIDTH−1 transfers: go to PAD if PAD > 0, otherwise start the next row.
  - PAD: emit PAD zero bytes. Then go to PIXEL for the next row, or to DONE after the last row.
  - After the last row's final byte (R byte, or last pad byte): go to DONE.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Handshake rules:
  - A byte transfers on `out_valid && out_ready`.
  - A pixel transfers on `pix_valid && pix_ready`.
  - `out_valid` = 1 in HEADER and PAD, and in PIXEL while the holding register is full.
  - While `out_valid` = 1 and `out_ready` = 0, `out_data` is stable.
- `pix_ready` = (state == PIXEL) && (holding register empty || (R byte presented && `out_ready` && not the last column)). This is combinational from `out_ready`, which allows back-to-back pixels.
- `start` while busy is ignored; an accepted `start` does not re-sample `gray_mode`.
- Pixels offered outside PIXEL are not accepted (`pix_ready` = 0).

## Timing
- Reset (`reset` = 0 at a clock edge):
  - State goes to IDLE; counters and the holding register are cleared.
  - Outputs become `out_valid` = 0, `out_data` = 0, `pix_ready` = 0, `busy` = 0, `done` = 0.
  - Reset mid-frame aborts the frame with no further bytes and no `done`.
- First header byte is valid in the cycle after `start` is accepted.
- Frame length is exactly FILE_SIZE byte transfers.
- With `out_ready` held at 1 and pixels always available, throughput is 1 byte per cycle (3 cycles per pixel).
- `done` asserts in the cycle after the final byte transfers. `busy` deasserts in the same cycle as `done`.

## Test plan
- Defaults (160×148), RGB mode, `out_ready` = 1:
  - Header bytes 0..5 = 66,77,182,21,1,0; bytes 18..25 = 160,0,0,0,148,0,0,0; bytes 34..37 = 128,21,1,0.
  - Total 71094 bytes; `done` pulses once.
- IMG_WIDTH = 5, IMG_HEIGHT = 2:
  - STRIDE = 16 and PAD = 1, so each row is 15 pixel bytes plus one byte of 0.
  - Total 86 bytes; header byte [2] = 86.
- Gray mode, `gray` = 0x7F, RGB inputs = 0x11/0x22/0x33 → every pixel byte = 0x7F.
- Pixel (R=0xAA, G=0xBB, B=0xCC), with `out_ready` = 0 for 10 cycles while the G byte is presented:
  - `out_data` is held at 0xBB and `pix_ready` = 0 during the stall.
  - The byte sequence continues 0xCC, 0xBB, 0xAA with no loss or duplication.
- `reset` = 0 during row 1:
  - Next cycle `out_valid` = 0 and `busy` = 0, with no `done`.
  - A new `start` restarts from header byte 66.
- `start` pulsed again mid-frame → ignored; byte count stays FILE_SIZE and `gray_mode` is unchanged for the frame.
